// File: rtl/router_pkg.sv
// Shared router types: flit encodings and default switch geometry.
package router_pkg;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flit_type_e;

    localparam int DEFAULT_NUM_PORTS = 5;

    function automatic logic is_head(input logic [1:0] t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/wormhole_xbar_switch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic         found;
    int           j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && !found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wormhole_xbar_switch.sv
// N-port wormhole crossbar: per-output RR arbitration, head-to-tail locking,
// one registered flit per output, malformed flits dropped and flagged.
module wormhole_xbar_switch
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int FLIT_W    = 32,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
    input  logic [NUM_PORTS*2-1:0]        in_type,
    input  logic [NUM_PORTS*PORT_W-1:0]   in_dst,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
    output logic [NUM_PORTS*2-1:0]        out_type,
    output logic [NUM_PORTS*PORT_W-1:0]   out_src,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS-1:0]          err_drop
);

    logic [FLIT_W-1:0]    flit      [NUM_PORTS];
    logic [1:0]           typ       [NUM_PORTS];
    logic [PORT_W-1:0]    dst       [NUM_PORTS];
    logic [NUM_PORTS-1:0] req       [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant     [NUM_PORTS];
    logic [PORT_W-1:0]    gidx      [NUM_PORTS];
    logic [PORT_W-1:0]    owner     [NUM_PORTS];
    logic [PORT_W-1:0]    bound_out [NUM_PORTS];
    logic [PORT_W-1:0]    psrc      [NUM_PORTS];
    logic [PORT_W-1:0]    tgt;
    logic [NUM_PORTS-1:0] hs, dst_ok, drop, xfer, gnt_in, body_go;
    logic [NUM_PORTS-1:0] can_acc, arb_en, push, lock, bound;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            flit[i]   = in_flit[i*FLIT_W +: FLIT_W];
            typ[i]    = in_type[i*2 +: 2];
            dst[i]    = in_dst[i*PORT_W +: PORT_W];
            hs[i]     = is_head(typ[i]);
            dst_ok[i] = int'(dst[i]) < NUM_PORTS;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            can_acc[o] = !out_valid[o] || out_ready[o];
            arb_en[o]  = !lock[o] && can_acc[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = in_valid[i] && hs[i] && dst_ok[i] && !bound[i]
                            && (dst[i] == PORT_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (req[o]),
            .en        (arb_en[o]),
            .grant     (grant[o]),
            .grant_idx (gidx[o])
        );
    end

    // A bound input may only stream body/tail; anything else is malformed.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_in[i] = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                gnt_in[i] = gnt_in[i] | grant[o][i];
            end
            drop[i] = in_valid[i] &&
                      (hs[i] ? (!dst_ok[i] || bound[i]) : !bound[i]);
            body_go[i]  = bound[i] && !hs[i] && can_acc[bound_out[i]];
            in_ready[i] = !rst && (drop[i] || gnt_in[i] || body_go[i]);
            xfer[i]     = in_valid[i] && in_ready[i] && !drop[i];
            err_drop[i] = !rst && drop[i];
        end
    end

    always_comb begin
        tgt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            push[o] = 1'b0;
            psrc[o] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            tgt = bound[i] ? bound_out[i] : dst[i];
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer[i] && tgt == PORT_W'(o)) begin
                    push[o] = 1'b1;
                    psrc[o] = PORT_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_flit  <= '0;
            out_type  <= '0;
            out_src   <= '0;
            lock      <= '0;
            bound     <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                owner[k]     <= '0;
                bound_out[k] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (push[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_flit[o*FLIT_W +: FLIT_W]  <= flit[psrc[o]];
                    out_type[o*2 +: 2]            <= typ[psrc[o]];
                    out_src[o*PORT_W +: PORT_W]   <= psrc[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
                if (|grant[o] && typ[gidx[o]] == HEAD) begin
                    lock[o]  <= 1'b1;
                    owner[o] <= gidx[o];
                end else if (lock[o] && xfer[owner[o]]
                             && typ[owner[o]] == TAIL) begin
                    lock[o] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt_in[i] && typ[i] == HEAD) begin
                    bound[i]     <= 1'b1;
                    bound_out[i] <= dst[i];
                end else if (xfer[i] && bound[i] && typ[i] == TAIL) begin
                    bound[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wormhole_xbar_switch.sv
// Directed bench for the wormhole crossbar with 5 ports and 32-bit flits.
module tb_wormhole_xbar_switch;
    import router_pkg::*;

    localparam int NP = 5;
    localparam int FW = 32;
    localparam int PW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    in_valid;
    logic [NP*FW-1:0] in_flit;
    logic [NP*2-1:0]  in_type;
    logic [NP*PW-1:0] in_dst;
    logic [NP-1:0]    in_ready;
    logic [NP-1:0]    out_valid;
    logic [NP*FW-1:0] out_flit;
    logic [NP*2-1:0]  out_type;
    logic [NP*PW-1:0] out_src;
    logic [NP-1:0]    out_ready;
    logic [NP-1:0]    err_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wormhole_xbar_switch #(.NUM_PORTS(NP), .FLIT_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_type   (in_type),
        .in_dst    (in_dst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_type  (out_type),
        .out_src   (out_src),
        .out_ready (out_ready),
        .err_drop  (err_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic v, input logic [1:0] t,
                       input logic [2:0] d, input logic [31:0] f);
        in_valid[i]        = v;
        in_type[i*2 +: 2]  = t;
        in_dst[i*PW +: PW] = d;
        in_flit[i*FW +: FW] = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int o, input logic [31:0] f,
                           input logic [1:0] t, input logic [2:0] s);
        chk({tag, " valid"}, 32'(out_valid[o]), 32'd1);
        chk({tag, " flit"}, out_flit[o*FW +: FW], f);
        chk({tag, " type"}, 32'(out_type[o*2 +: 2]), 32'(t));
        chk({tag, " src"}, 32'(out_src[o*PW +: PW]), 32'(s));
    endtask

    initial begin
        logic [1:0] t;
        rst       = 1'b1;
        in_valid  = '0;
        in_flit   = '0;
        in_type   = '0;
        in_dst    = '0;
        out_ready = '1;

        // reset state, with a head already presented
        drv(0, 1, HEAD, 2, 32'hA0);
        tick();
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst err_drop", 32'(err_drop), 32'h0);
        chk("rst out_flit0", out_flit[31:0], 32'h0);
        rst = 1'b0;

        // single 4-flit path 0 -> 2
        for (int k = 0; k < 4; k++) begin
            t = (k == 0) ? HEAD : (k == 3) ? TAIL : BODY;
            drv(0, 1, t, 2, 32'hA0 + 32'(k));
            #1;
            chk($sformatf("t1 rdy%0d", k), 32'(in_ready), 32'b00001);
            tick();
            chk_out($sformatf("t1 f%0d", k), 2, 32'hA0 + 32'(k), t, 0);
        end
        drv(0, 0, HEAD, 0, 0);
        drv(1, 1, SINGLE, 2, 32'hA9);
        #1;
        chk("t1 unlock rdy", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t1 single", 2, 32'hA9, SINGLE, 1);
        drv(1, 0, HEAD, 0, 0);
        tick();
        chk("t1 drain", 32'(out_valid), 32'h0);

        // contention on output 0 from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(1, 1, HEAD, 0, 32'h10);
        drv(3, 1, HEAD, 0, 32'h30);
        drv(4, 1, HEAD, 0, 32'h40);
        #1 chk("t2 rdy h1", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t2 h1", 0, 32'h10, HEAD, 1);
        drv(1, 1, BODY, 0, 32'h11);
        #1 chk("t2 rdy b1", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t2 b1", 0, 32'h11, BODY, 1);
        drv(1, 1, TAIL, 0, 32'h12);
        #1 chk("t2 rdy t1", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t2 t1", 0, 32'h12, TAIL, 1);
        drv(1, 0, HEAD, 0, 0);
        #1 chk("t2 rdy h3", 32'(in_ready), 32'b01000);
        tick();
        chk_out("t2 h3", 0, 32'h30, HEAD, 3);
        drv(3, 1, TAIL, 0, 32'h31);
        #1 chk("t2 rdy t3", 32'(in_ready), 32'b01000);
        tick();
        chk_out("t2 t3", 0, 32'h31, TAIL, 3);
        drv(3, 0, HEAD, 0, 0);
        #1 chk("t2 rdy h4", 32'(in_ready), 32'b10000);
        tick();
        chk_out("t2 h4", 0, 32'h40, HEAD, 4);
        drv(4, 1, TAIL, 0, 32'h41);
        #1 chk("t2 rdy t4", 32'(in_ready), 32'b10000);
        tick();
        chk_out("t2 t4", 0, 32'h41, TAIL, 4);
        drv(4, 0, HEAD, 0, 0);
        tick();
        chk("t2 drain", 32'(out_valid), 32'h0);

        // backpressure mid-packet on output 2
        drv(0, 1, HEAD, 2, 32'hB0);
        #1 chk("t3 rdy h", 32'(in_ready), 32'b00001);
        tick();
        chk_out("t3 h", 2, 32'hB0, HEAD, 0);
        drv(0, 1, BODY, 0, 32'hB1);
        tick();
        chk_out("t3 b1", 2, 32'hB1, BODY, 0);
        drv(0, 1, BODY, 0, 32'hB2);
        out_ready = 5'b11011;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("t3 stall rdy%0d", k), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("t3 stall%0d", k), 2, 32'hB1, BODY, 0);
        end
        out_ready = '1;
        #1 chk("t3 resume rdy", 32'(in_ready), 32'b00001);
        tick();
        chk_out("t3 b2", 2, 32'hB2, BODY, 0);
        drv(0, 1, TAIL, 0, 32'hB3);
        tick();
        chk_out("t3 t", 2, 32'hB3, TAIL, 0);
        drv(0, 0, HEAD, 0, 0);
        tick();
        chk("t3 drain", 32'(out_valid), 32'h0);

        // parallel 8-flit packets 0->1 and 2->3
        for (int k = 0; k < 8; k++) begin
            t = (k == 0) ? HEAD : (k == 7) ? TAIL : BODY;
            drv(0, 1, t, 1, 32'hC0 + 32'(k));
            drv(2, 1, t, 3, 32'hD0 + 32'(k));
            #1 chk($sformatf("t4 rdy%0d", k), 32'(in_ready), 32'b00101);
            tick();
            chk_out($sformatf("t4 o1 f%0d", k), 1, 32'hC0 + 32'(k), t, 0);
            chk_out($sformatf("t4 o3 f%0d", k), 3, 32'hD0 + 32'(k), t, 2);
        end
        drv(0, 0, HEAD, 0, 0);
        drv(2, 0, HEAD, 0, 0);
        tick();

        // SINGLE flits alternating on output 4
        drv(0, 1, SINGLE, 4, 32'hE0);
        drv(1, 1, SINGLE, 4, 32'hF0);
        #1 chk("t5 rdy c1", 32'(in_ready), 32'b00001);
        tick();
        chk_out("t5 c1", 4, 32'hE0, SINGLE, 0);
        drv(0, 1, SINGLE, 4, 32'hE1);
        #1 chk("t5 rdy c2", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t5 c2", 4, 32'hF0, SINGLE, 1);
        drv(1, 1, SINGLE, 4, 32'hF1);
        #1 chk("t5 rdy c3", 32'(in_ready), 32'b00001);
        tick();
        chk_out("t5 c3", 4, 32'hE1, SINGLE, 0);
        drv(0, 0, HEAD, 0, 0);
        #1 chk("t5 rdy c4", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t5 c4", 4, 32'hF1, SINGLE, 1);
        drv(1, 0, HEAD, 0, 0);
        drv(2, 1, SINGLE, 4, 32'hE9);
        #1 chk("t5 nolock rdy", 32'(in_ready), 32'b00100);
        tick();
        chk_out("t5 c5", 4, 32'hE9, SINGLE, 2);
        drv(2, 0, HEAD, 0, 0);
        tick();

        // malformed traffic
        drv(0, 1, HEAD, 7, 32'hBAD);
        #1;
        chk("t6 bad dst rdy", 32'(in_ready), 32'b00001);
        chk("t6 bad dst err", 32'(err_drop), 32'b00001);
        tick();
        chk("t6 bad dst outv", 32'(out_valid), 32'h0);
        drv(0, 0, HEAD, 0, 0);
        drv(2, 1, BODY, 0, 32'hBAD2);
        #1;
        chk("t6 orphan rdy", 32'(in_ready), 32'b00100);
        chk("t6 orphan err", 32'(err_drop), 32'b00100);
        tick();
        chk("t6 orphan outv", 32'(out_valid), 32'h0);
        drv(2, 0, HEAD, 0, 0);
        #1 chk("t6 err clear", 32'(err_drop), 32'h0);

        // reset in the middle of a packet
        drv(0, 1, HEAD, 2, 32'h70);
        #1 chk("t7 rdy h", 32'(in_ready), 32'b00001);
        tick();
        chk_out("t7 h", 2, 32'h70, HEAD, 0);
        rst = 1'b1;
        drv(0, 1, BODY, 0, 32'h71);
        #1 chk("t7 rst rdy", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;
        drv(0, 0, HEAD, 0, 0);
        #1 chk("t7 post outv", 32'(out_valid), 32'h0);
        drv(1, 1, HEAD, 2, 32'h72);
        #1 chk("t7 new rdy", 32'(in_ready), 32'b00010);
        tick();
        chk_out("t7 new h", 2, 32'h72, HEAD, 1);
        drv(1, 1, TAIL, 0, 32'h73);
        drv(0, 1, BODY, 0, 32'h74);
        #1;
        chk("t7 tail rdy", 32'(in_ready), 32'b00011);
        chk("t7 stale err", 32'(err_drop), 32'b00001);
        tick();
        chk_out("t7 tail", 2, 32'h73, TAIL, 1);
        in_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wormhole_xbar_switch.md
Name: wormhole_xbar_switch

Overview:
- Parametrised N-port wormhole crossbar switch for the router datapath, placed between route computation and the output link registers.
- Each output has its own round-robin arbiter over head flits addressed to it. A winning input locks the output until its tail flit transfers.
- Outputs are registered with valid/ready backpressure, one flit buffered per output.
- Malformed traffic (bad destination, orphan body/tail flit) is dropped and flagged.

Parameters:
- NUM_PORTS, 5, number of input and output ports (2..16).
- FLIT_W, 32, flit payload width in bits.
- PORT_W, $clog2(NUM_PORTS), width of a port index (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_PORTS  per-input flit valid.
- in_flit  in  NUM_PORTS*FLIT_W  per-input payload; input i occupies slice [i*FLIT_W +: FLIT_W].
- in_type  in  NUM_PORTS*2  flit type per input: HEAD=0, BODY=1, TAIL=2, SINGLE=3.
- in_dst  in  NUM_PORTS*PORT_W  destination output; sampled only on HEAD/SINGLE.
- in_ready  out  NUM_PORTS  per-input accept; a transfer occurs when in_valid&in_ready.
- out_valid  out  NUM_PORTS  per-output registered flit valid.
- out_flit  out  NUM_PORTS*FLIT_W  registered payload.
- out_type  out  NUM_PORTS*2  registered flit type.
- out_src  out  NUM_PORTS*PORT_W  source input index of the registered flit.
- out_ready  in  NUM_PORTS  downstream accept per output.
- err_drop  out  NUM_PORTS  one-cycle pulse per input when a flit is dropped.

Behaviour:
- Reset (rst high at a clk edge): out_valid=0, out_flit/out_type/out_src=0, err_drop=0, all locks cleared, all RR pointers=0. in_ready is combinational; it is 0 while rst is high.
- A reset in mid-packet discards the packet state. There is no recovery of partial packets.
- Per-output state: lock (1 bit), owner (PORT_W), rr_ptr (PORT_W).
- Per-input state: bound (1 bit), bound_out (PORT_W). An input owns at most one output.
- Output slot can accept when: !out_valid[o] || out_ready[o].
- Request: input i requests output d when in_valid[i], type is HEAD or SINGLE, d < NUM_PORTS, and !bound[i].
- Grant: an unlocked output whose slot can accept grants one requester per cycle.
  - Search order starts at rr_ptr and wraps modulo NUM_PORTS.
  - On a grant, rr_ptr becomes winner+1 (wrapping).
  - The grant is combinational; the head flit transfers in the same cycle (in_ready=1). The flit is registered at the output, so latency is 1 cycle from input transfer to out_valid.
- Lock on grant:
  - HEAD: set lock[d], owner[d]=i, bound[i]=1, bound_out[i]=d.
  - SINGLE: no lock is set.
- Body/tail on a bound input: in_ready[i] equals the accept condition of slot bound_out[i].
  - A TAIL transfer clears lock and bound at the clock edge.
  - The freed output can grant a new head no earlier than the next cycle.
- Losing or blocked heads: in_ready=0, and the flit is held upstream unchanged.
- Drops: in_ready=1, the flit is discarded, and err_drop[i]=1 for that cycle. A flit is dropped when:
  - it is HEAD/SINGLE with in_dst >= NUM_PORTS;
  - it is BODY/TAIL on an unbound input;
  - it is HEAD/SINGLE on a bound input.
- Output register: loads flit/type/src on transfer. Otherwise, out_valid clears when out_ready[o]=1, and the held flit is stable while out_ready=0.
- Simultaneous events:
  - A tail leaving output o and a head requesting o in the same cycle: the head waits one cycle.
  - Pop and push on the same output slot in the same cycle: full throughput, 1 flit/cycle/output.
- Loopback (dst == source index) is legal.

Decomposition:
- Shared package (extend router_pkg):
  - flit_type_e enum: HEAD, BODY, TAIL, SINGLE.
  - Default NUM_PORTS.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: clk, rst, req[N], en, grant[N] one-hot, grant_idx.
  - Pointer updates only when en is high and a grant is made.
  - One instance per output.

Test Plan:
- Single path, 4-flit packet (HEAD dst=2, BODY, BODY, TAIL) on input 0 with out_ready=1 → out_valid[2] high on 4 consecutive cycles starting 1 cycle after the head; out_src=0; lock[2] clears after the tail.
- Contention: inputs 1,3,4 send HEAD dst=0 in the same cycle from reset → packets granted in order 1, 3, 4. Each packet is contiguous on output 0, with no interleaving.
- Backpressure: out_ready[2]=0 for 3 cycles mid-packet → in_ready[0]=0 during the stall and out_flit[2] is stable; the flow resumes without loss or duplication.
- Parallel paths: 0→1 and 2→3 concurrently, 8-flit packets → both outputs run at 1 flit/cycle.
- SINGLE flits from inputs 0 and 1, both to output 4, back-to-back → they alternate fairly; no lock is ever set.
- Errors: HEAD dst=7 with NUM_PORTS=5, and an orphan BODY on input 2 → err_drop pulses once each; out_valid is unaffected.
- Reset mid-packet: rst=1 for 1 cycle after the head → all outputs are invalid and unlocked, and a new HEAD is granted immediately after reset deasserts.
